twos_comp_to_sign_bcd: RTL and testbench

//   Inverse path of the sign-magnitude -> two's complement converter. Takes a

---
 rtl/twos_comp_to_sign_bcd.sv | 103 ++++++++++
 tb/tb_twos_comp_to_sign_bcd.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/twos_comp_to_sign_bcd.sv
// Converts a signed two's-complement value to sign, magnitude and packed BCD
// using a sequential double-dabble with a start/busy/done handshake.
module twos_comp_to_sign_bcd #(
  parameter int bits   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [bits:0]         value,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [bits:0]         magnitude,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(bits + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(bits + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] scratch_adj;
  logic [4*DIGITS-1:0] next_scratch;
  logic [bits:0]       work_mag;
  logic [bits:0]       mag_hold;
  logic [bits:0]       abs_mag;
  logic                work_sign;

  // Magnitude comes straight from the operand; -2**bits fits because the
  // result is bits+1 wide.
  assign abs_mag = value[bits] ? (~value + 1'b1) : value;

  // NOTE: every always_comb output gets a default before any conditional
  // update so no latch can be inferred.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    next_scratch = {scratch_adj[4*DIGITS-2:0], work_mag[bits]};
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      scratch   <= '0;
      work_mag  <= '0;
      mag_hold  <= '0;
      work_sign <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sign      <= 1'b0;
      magnitude <= '0;
      bcd       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CONV;
            busy      <= 1'b1;
            work_sign <= value[bits];
            work_mag  <= abs_mag;
            mag_hold  <= abs_mag;
            scratch   <= '0;
            count     <= CNT_INIT;
          end
        end
        CONV: begin
          scratch  <= next_scratch;
          work_mag <= {work_mag[bits-1:0], 1'b0};
          count    <= count - CW'(1);
          // Visible outputs change only on the final shift to avoid flicker.
          if (count == CW'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            sign      <= work_sign;
            magnitude <= mag_hold;
            bcd       <= next_scratch;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_comp_to_sign_bcd.sv
// Bench for twos_comp_to_sign_bcd: cycle-level behavioural model checked every
// cycle, plus directed vectors with hand-computed results.
module tb_twos_comp_to_sign_bcd;

  localparam int B = 8;
  localparam int D = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [B:0]      value = '0;
  logic            busy, done, sign;
  logic [B:0]      magnitude;
  logic [4*D-1:0]  bcd;

  int checks = 0;
  int errors = 0;

  twos_comp_to_sign_bcd #(.bits(B), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .sign(sign), .magnitude(magnitude), .bcd(bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from plain arithmetic.
  function automatic int ref_mag(input logic [B:0] v);
    int s;
    s = $signed(v);
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [4*D-1:0] ref_bcd(input int m);
    logic [4*D-1:0] r;
    int x;
    x = m;
    r = '0;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Cycle model: phase 0 = idle, 1..B+2 = cycles since start accepted.
  int             m_phase = 0;
  logic [B:0]     m_pend = '0;
  logic           m_sign = 1'b0;
  logic [B:0]     m_mag = '0;
  logic [4*D-1:0] m_bcd = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_sign  = 1'b0;
      m_mag   = '0;
      m_bcd   = '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_pend  = value;
      end
    end else begin
      m_phase++;
      if (m_phase == B + 2) begin
        m_sign = ($signed(m_pend) < 0);
        m_mag  = (B+1)'(ref_mag(m_pend));
        m_bcd  = ref_bcd(ref_mag(m_pend));
      end
      if (m_phase == B + 3) m_phase = 0;
    end
  end

  always @(negedge clk) begin
    check("busy", busy, (m_phase != 0));
    check("done", done, (m_phase == B + 2));
    check("sign", sign, m_sign);
    check("magnitude", magnitude, m_mag);
    check("bcd", bcd, m_bcd);
  end

  // Pulse start for one cycle, then wait (bounded) for done; returns latency.
  task automatic convert(input logic [B:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", done, 1'b1);
  endtask

  int lat;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_bcd", bcd, 12'h000);
    rst = 1'b0;

    convert(9'd37, lat);
    check("latency", lat, B + 2);
    check("v37_sign", sign, 1'b0);
    check("v37_mag", magnitude, 9'd37);
    check("v37_bcd", bcd, 12'h037);

    convert(9'h1FF, lat);
    check("vm1_sign", sign, 1'b1);
    check("vm1_mag", magnitude, 9'd1);
    check("vm1_bcd", bcd, 12'h001);

    convert(9'h100, lat);
    check("vm256_sign", sign, 1'b1);
    check("vm256_mag", magnitude, 9'd256);
    check("vm256_bcd", bcd, 12'h256);
    @(negedge clk);
    check("hold_bcd", bcd, 12'h256);

    convert(9'd0, lat);
    check("zero_sign", sign, 1'b0);
    check("zero_mag", magnitude, 9'd0);
    check("zero_bcd", bcd, 12'h000);

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1;
    value = 9'd255;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    value = 9'h1FB;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done", done, 1'b1);
    check("ign_sign", sign, 1'b0);
    check("ign_mag", magnitude, 9'd255);
    check("ign_bcd", bcd, 12'h255);
    @(negedge clk);
    check("ign_no_second", busy, 1'b0);

    // reset mid-conversion aborts without a done pulse
    @(negedge clk);
    start = 1'b1;
    value = 9'h180;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_mag", magnitude, 9'd0);
    check("abort_bcd", bcd, 12'h000);
    repeat (12) @(negedge clk);

    convert(9'h180, lat);
    check("m128_sign", sign, 1'b1);
    check("m128_mag", magnitude, 9'd128);
    check("m128_bcd", bcd, 12'h128);

    // start held high: back-to-back conversions
    @(negedge clk);
    start = 1'b1;
    value = 9'h19C;
    repeat (3 * (B + 3)) @(negedge clk);
    start = 1'b0;
    repeat (B + 4) @(negedge clk);
    check("b2b_bcd", bcd, 12'h100);

    // sweep of every input value, checked by the per-cycle model
    for (int i = 0; i < 512; i++) begin
      convert((B+1)'(i), lat);
      check("sweep_latency", lat, B + 2);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
